// File: rtl/ss_defs.sv
// ss_defs: shared scan-state encodings and hex segment table for display blocks
package ss_defs;
  typedef enum logic [1:0] {BLANK_L = 2'd0, SHOW_L = 2'd1, BLANK_M = 2'd2, SHOW_M = 2'd3} scan_state_t;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: nibble to active-high segments (bit0=A .. bit6=G)
module seven_seg_decoder
  import ss_defs::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = SEG_TABLE[nib];
endmodule

// File: rtl/ss_scan_ctrl.sv
// ss_scan_ctrl: two-digit multiplexed seven-segment scanner with frame-aligned data update
module ss_scan_ctrl
  import ss_defs::*;
#(
  parameter int DIGIT_CYCLES = 12000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       blank_en,
  input  logic       lz_suppress,
  output logic [6:0] seg,
  output logic       dig_sel,
  output logic       frame_tick
);
  localparam int MAXC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
  scan_state_t state, state_n;
  logic [TW-1:0] timer;
  logic [7:0] active, shadow;
  logic pending, show, last, wrap, msd_zero;
  logic [3:0] nib;
  logic [6:0] dec;
  always_comb begin
    show = state == SHOW_L || state == SHOW_M;
    last = timer == (show ? TW'(DIGIT_CYCLES - 1) : TW'(BLANK_CYCLES - 1));
    state_n = last ? scan_state_t'(state + 2'd1) : state;
    wrap = last && state == SHOW_M;
    dig_sel = state == BLANK_M || state == SHOW_M;
    nib = dig_sel ? active[7:4] : active[3:0];
    msd_zero = active[7:4] == 4'd0;
    seg = (show && !blank_en && !(state == SHOW_M && lz_suppress && msd_zero)) ? dec : 7'd0;
    frame_tick = wrap;
    din_ready = !pending;
  end
  seven_seg_decoder u_dec (.nib(nib), .seg(dec));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BLANK_L;
      timer <= '0;
      active <= 8'h00;
      shadow <= 8'h00;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      timer <= last ? '0 : timer + 1'b1;
      // a transfer needs pending=0, so it can never collide with promotion
      if (din_valid && !pending) begin
        shadow <= din;
        pending <= 1'b1;
      end else if (wrap && pending) begin
        active <= shadow;
        pending <= 1'b0;
      end
    end
  end
endmodule
